// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: defaults, fetch FSM
// encoding, pcsrcd encodings and the next-PC source selector.
package pipe_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  // pcsrcd encodings coming from decode control ({jumpd, equald&branchd})
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  // REQ : request outstanding on the current PCF
  // HOLD: word captured while decode is stalled, request dropped
  // KILL: wrong-path access still outstanding, redirect target saved
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_t;

  // Where the PC register takes its next value from
  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_SEQ    = 2'd1,
    PC_TARGET = 2'd2,
    PC_SAVED  = 2'd3
  } pc_sel_t;

  // MIPS J-type target: upper nibble of PC+4, 26-bit word index, word aligned
  function automatic logic [31:0] jump_target(input logic [3:0]  pcp4_hi,
                                              input logic [25:0] idx);
    return {pcp4_hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: PC+4, redirect target (jump beats branch)
// and the final mux feeding the PC register.
module fetch_pc_sel
  import pipe_pkg::*;
(
  input  logic [31:0] pcf_i,
  input  pc_sel_t     sel_i,
  input  logic        jump_i,
  input  logic [31:0] pcbranchd_i,
  input  logic [25:0] jidx_i,
  input  logic [3:0]  pcplus4d_hi_i,
  input  logic [31:0] saved_i,
  output logic [31:0] pcplus4f_o,
  output logic [31:0] target_o,
  output logic [31:0] next_pc_o
);

  // PC+4 wraps modulo 2^32; target is used as given (no realignment)
  always_comb begin
    pcplus4f_o = pcf_i + 32'd4;
    target_o   = jump_i ? jump_target(pcplus4d_hi_i, jidx_i) : pcbranchd_i;
  end

  // Next-PC source mux
  always_comb begin
    next_pc_o = pcf_i;
    case (sel_i)
      PC_KEEP:   next_pc_o = pcf_i;
      PC_SEQ:    next_pc_o = pcplus4f_o;
      PC_TARGET: next_pc_o = target_o;
      PC_SAVED:  next_pc_o = saved_i;
      default:   next_pc_o = pcf_i;
    endcase
  end

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage plus IF/ID register. Holds PCF, talks to a
// variable-latency instruction memory, honours decode stalls and kills the
// wrong-path fetch on a taken branch or jump.
//
// Memory handshake: imem_req and imem_addr are registered. While imem_req=1
// the address is held until a cycle with imem_ready=1; that cycle's
// imem_rdata is consumed at the rising edge. imem_ready is ignored whenever
// imem_req=0 (including the reset cycle and the first cycle after release).
module pipe_fetch
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_WORD
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stalld,
  input  logic [1:0]   pcsrcd,
  input  logic [31:0]  pcbranchd,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instrd,
  output logic [31:0]  pcplus4d,
  output logic         validd,
  output fetch_state_t dbg_state_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pcp4_q, buf_pcp4_d;
  logic [31:0]  saved_q, saved_d;
  logic [31:0]  instrd_q, instrd_d;
  logic [31:0]  pcplus4d_q, pcplus4d_d;
  logic         validd_q, validd_d;
  logic         req_q, req_d;

  pc_sel_t      pc_sel;
  logic [31:0]  pcplus4f;
  logic [31:0]  target;
  logic         redirect;
  logic         rdy;
  logic         deliver;
  logic [31:0]  deliver_instr;
  logic [31:0]  deliver_pcp4;

  // Decode only redirects for a real, unstalled instruction
  assign redirect = validd_q & ~stalld & (pcsrcd != PCSRC_SEQ);
  assign rdy      = imem_ready & req_q;

  fetch_pc_sel u_pc_sel (
    .pcf_i         (pcf_q),
    .sel_i         (pc_sel),
    .jump_i        (pcsrcd[1]),
    .pcbranchd_i   (pcbranchd),
    .jidx_i        (instrd_q[25:0]),
    .pcplus4d_hi_i (pcplus4d_q[31:28]),
    .saved_i       (saved_q),
    .pcplus4f_o    (pcplus4f),
    .target_o      (target),
    .next_pc_o     (pcf_d)
  );

  // Fetch FSM next-state, PC source, hold buffer and IF/ID load decisions
  always_comb begin
    state_d       = state_q;
    pc_sel        = PC_KEEP;
    buf_instr_d   = buf_instr_q;
    buf_pcp4_d    = buf_pcp4_q;
    saved_d       = saved_q;
    deliver       = 1'b0;
    deliver_instr = NOP;
    deliver_pcp4  = 32'd0;

    case (state_q)
      ST_REQ: begin
        if (rdy) begin
          if (redirect) begin
            pc_sel = PC_TARGET;
          end else if (!stalld) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            deliver_pcp4  = pcplus4f;
            pc_sel        = PC_SEQ;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pcp4_d  = pcplus4f;
            state_d     = ST_HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable until the outstanding access returns
          saved_d = target;
          state_d = ST_KILL;
        end
      end
      ST_HOLD: begin
        if (!stalld) begin
          state_d = ST_REQ;
          if (redirect) begin
            pc_sel = PC_TARGET;
          end else begin
            deliver       = 1'b1;
            deliver_instr = buf_instr_q;
            deliver_pcp4  = buf_pcp4_q;
            pc_sel        = PC_SEQ;
          end
        end
      end
      ST_KILL: begin
        if (rdy) begin
          pc_sel  = PC_SAVED;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // IF/ID: stall holds, redirect or no delivery inserts a bubble
    instrd_d   = instrd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;
    if (!stalld) begin
      if (deliver && !redirect) begin
        instrd_d   = deliver_instr;
        pcplus4d_d = deliver_pcp4;
        validd_d   = 1'b1;
      end else begin
        instrd_d   = NOP;
        pcplus4d_d = pcplus4d_q;
        validd_d   = 1'b0;
      end
    end

    req_d = (state_d != ST_HOLD);
  end

  // All fetch-stage state, including the registered memory request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_REQ;
      pcf_q       <= RESET_PC;
      buf_instr_q <= NOP;
      buf_pcp4_q  <= 32'd0;
      saved_q     <= 32'd0;
      instrd_q    <= NOP;
      pcplus4d_q  <= 32'd0;
      validd_q    <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      buf_instr_q <= buf_instr_d;
      buf_pcp4_q  <= buf_pcp4_d;
      saved_q     <= saved_d;
      instrd_q    <= instrd_d;
      pcplus4d_q  <= pcplus4d_d;
      validd_q    <= validd_d;
      req_q       <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pcf_q;
  assign instrd      = instrd_q;
  assign pcplus4d    = pcplus4d_q;
  assign validd      = validd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// Directed bench for pipe_fetch: sequential fetch, wait states, stall/hold,
// branch kill, jump priority, PC wrap and reset during a killed access.
module tb_pipe_fetch;
  import pipe_pkg::*;

  logic         clk;
  logic         reset;
  logic         stalld;
  logic [1:0]   pcsrcd;
  logic [31:0]  pcbranchd;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ready;
  logic [31:0]  imem_rdata;
  logic [31:0]  instrd;
  logic [31:0]  pcplus4d;
  logic         validd;
  fetch_state_t dbg_state;

  int passed;
  int total;

  pipe_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stalld      (stalld),
    .pcsrcd      (pcsrcd),
    .pcbranchd   (pcbranchd),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instrd      (instrd),
    .pcplus4d    (pcplus4d),
    .validd      (validd),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stalld     = 1'b0;
    pcsrcd     = 2'b00;
    pcbranchd  = 32'd0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
  endtask

  // Reset, release, and one edge so the request is up at RESET_PC
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 00000000", imem_addr); else passed++;
    total++; if (validd !== 1'b0) $display("FAIL rst_valid: got %b exp 0", validd); else passed++;
    total++; if (instrd !== 32'h0) $display("FAIL rst_instr: got %h exp 00000000", instrd); else passed++;
    total++; if (pcplus4d !== 32'h0) $display("FAIL rst_pcp4: got %h exp 00000000", pcplus4d); else passed++;
    total++; if (dbg_state !== ST_REQ) $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_REQ); else passed++;
    // First edge after release: request rises, ready is not yet consumed
    reset = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h1;
    step();
    total++; if (imem_req !== 1'b1) $display("FAIL rel_req: got %b exp 1", imem_req); else passed++;
    total++; if (validd !== 1'b0) $display("FAIL rel_valid: got %b exp 0", validd); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rel_addr: got %h exp 00000000", imem_addr); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [3];
    logic [31:0] exp_pcp4  [3];
    exp_instr[0] = 32'h1; exp_instr[1] = 32'h5; exp_instr[2] = 32'h9;
    exp_pcp4[0]  = 32'h4; exp_pcp4[1]  = 32'h8; exp_pcp4[2]  = 32'hC;
    do_reset();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = exp_instr[i];
      step();
      total++; if (instrd !== exp_instr[i]) $display("FAIL seq_instr%0d: got %h exp %h", i, instrd, exp_instr[i]); else passed++;
      total++; if (pcplus4d !== exp_pcp4[i]) $display("FAIL seq_pcp4%0d: got %h exp %h", i, pcplus4d, exp_pcp4[i]); else passed++;
      total++; if (validd !== 1'b1) $display("FAIL seq_valid%0d: got %b exp 1", i, validd); else passed++;
      total++; if (imem_addr !== exp_pcp4[i]) $display("FAIL seq_addr%0d: got %h exp %h", i, imem_addr, exp_pcp4[i]); else passed++;
    end
    imem_ready = 1'b0;
  endtask

  task automatic test_var_latency();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_addr !== 32'h0) $display("FAIL lat_addr%0d: got %h exp 00000000", i, imem_addr); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL lat_req%0d: got %b exp 1", i, imem_req); else passed++;
      total++; if (validd !== 1'b0) $display("FAIL lat_valid%0d: got %b exp 0", i, validd); else passed++;
    end
    imem_ready = 1'b1;
    imem_rdata = 32'hAAAA_0001;
    step();
    imem_ready = 1'b0;
    total++; if (validd !== 1'b1) $display("FAIL lat_valid_out: got %b exp 1", validd); else passed++;
    total++; if (instrd !== 32'hAAAA_0001) $display("FAIL lat_instr: got %h exp aaaa0001", instrd); else passed++;
    total++; if (pcplus4d !== 32'h4) $display("FAIL lat_pcp4: got %h exp 00000004", pcplus4d); else passed++;
    total++; if (imem_addr !== 32'h4) $display("FAIL lat_addr_next: got %h exp 00000004", imem_addr); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h1;
    step();
    imem_rdata = 32'h5;
    step();
    // Word at 8 returns while decode is stalled
    stalld = 1'b1;
    imem_rdata = 32'h9;
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (dbg_state !== ST_HOLD) $display("FAIL stall_state%0d: got %0d exp %0d", i, dbg_state, ST_HOLD); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL stall_req%0d: got %b exp 0", i, imem_req); else passed++;
      total++; if (instrd !== 32'h5) $display("FAIL stall_instr%0d: got %h exp 00000005", i, instrd); else passed++;
      total++; if (imem_addr !== 32'h8) $display("FAIL stall_addr%0d: got %h exp 00000008", i, imem_addr); else passed++;
      if (i < 3) step();
    end
    stalld = 1'b0;
    step();
    total++; if (instrd !== 32'h9) $display("FAIL unstall_instr: got %h exp 00000009", instrd); else passed++;
    total++; if (pcplus4d !== 32'hC) $display("FAIL unstall_pcp4: got %h exp 0000000c", pcplus4d); else passed++;
    total++; if (validd !== 1'b1) $display("FAIL unstall_valid: got %b exp 1", validd); else passed++;
    total++; if (imem_addr !== 32'hC) $display("FAIL unstall_addr: got %h exp 0000000c", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL unstall_req: got %b exp 1", imem_req); else passed++;
  endtask

  task automatic test_branch_kill();
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h1;
    step();
    imem_ready = 1'b0;
    pcsrcd     = PCSRC_BR;
    pcbranchd  = 32'h40;
    step();
    pcsrcd = PCSRC_SEQ;
    total++; if (dbg_state !== ST_KILL) $display("FAIL br_state: got %0d exp %0d", dbg_state, ST_KILL); else passed++;
    total++; if (validd !== 1'b0) $display("FAIL br_valid: got %b exp 0", validd); else passed++;
    total++; if (instrd !== 32'h0) $display("FAIL br_instr: got %h exp 00000000", instrd); else passed++;
    total++; if (imem_addr !== 32'h4) $display("FAIL br_addr_hold: got %h exp 00000004", imem_addr); else passed++;
    step();
    total++; if (imem_addr !== 32'h4) $display("FAIL br_addr_hold2: got %h exp 00000004", imem_addr); else passed++;
    total++; if (imem_req !== 1'b1) $display("FAIL br_req: got %b exp 1", imem_req); else passed++;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    total++; if (validd !== 1'b0) $display("FAIL br_discard: got %b exp 0", validd); else passed++;
    total++; if (imem_addr !== 32'h40) $display("FAIL br_target: got %h exp 00000040", imem_addr); else passed++;
    total++; if (dbg_state !== ST_REQ) $display("FAIL br_state_req: got %0d exp %0d", dbg_state, ST_REQ); else passed++;
    imem_rdata = 32'h41;
    step();
    imem_ready = 1'b0;
    total++; if (instrd !== 32'h41) $display("FAIL br_new_instr: got %h exp 00000041", instrd); else passed++;
    total++; if (pcplus4d !== 32'h44) $display("FAIL br_new_pcp4: got %h exp 00000044", pcplus4d); else passed++;
  endtask

  task automatic test_jump_priority();
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h1;
    step();
    pcsrcd     = PCSRC_BR;
    pcbranchd  = 32'h1000_0004;
    imem_rdata = 32'h1234_5678;
    step();
    pcsrcd     = PCSRC_SEQ;
    imem_rdata = 32'h0800_0010;
    step();
    total++; if (instrd !== 32'h0800_0010) $display("FAIL j_instr: got %h exp 08000010", instrd); else passed++;
    total++; if (pcplus4d !== 32'h1000_0008) $display("FAIL j_pcp4: got %h exp 10000008", pcplus4d); else passed++;
    pcsrcd     = 2'b11;
    pcbranchd  = 32'h80;
    imem_rdata = 32'hFFFF_FFFF;
    step();
    pcsrcd     = PCSRC_SEQ;
    imem_ready = 1'b0;
    total++; if (imem_addr !== 32'h1000_0040) $display("FAIL j_target: got %h exp 10000040", imem_addr); else passed++;
    total++; if (validd !== 1'b0) $display("FAIL j_valid: got %b exp 0", validd); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h1;
    step();
    pcsrcd     = PCSRC_BR;
    pcbranchd  = 32'hFFFF_FFFC;
    step();
    pcsrcd     = PCSRC_SEQ;
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h exp fffffffc", imem_addr); else passed++;
    imem_rdata = 32'hCAFE_0000;
    step();
    imem_ready = 1'b0;
    total++; if (pcplus4d !== 32'h0) $display("FAIL wrap_pcp4: got %h exp 00000000", pcplus4d); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL wrap_next: got %h exp 00000000", imem_addr); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1'b1;
    imem_rdata = 32'h1;
    step();
    imem_ready = 1'b0;
    pcsrcd     = PCSRC_BR;
    pcbranchd  = 32'h40;
    step();
    pcsrcd = PCSRC_SEQ;
    total++; if (dbg_state !== ST_KILL) $display("FAIL rm_kill: got %0d exp %0d", dbg_state, ST_KILL); else passed++;
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h5555_5555;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rm_req: got %b exp 0", imem_req); else passed++;
    total++; if (validd !== 1'b0) $display("FAIL rm_valid: got %b exp 0", validd); else passed++;
    total++; if (instrd !== 32'h0) $display("FAIL rm_instr: got %h exp 00000000", instrd); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rm_addr: got %h exp 00000000", imem_addr); else passed++;
    total++; if (dbg_state !== ST_REQ) $display("FAIL rm_state: got %0d exp %0d", dbg_state, ST_REQ); else passed++;
    step();
    reset = 1'b0;
    step();
    total++; if (imem_req !== 1'b1) $display("FAIL rm_rel_req: got %b exp 1", imem_req); else passed++;
    total++; if (imem_addr !== 32'h0) $display("FAIL rm_rel_addr: got %h exp 00000000", imem_addr); else passed++;
    total++; if (validd !== 1'b0) $display("FAIL rm_rel_valid: got %b exp 0", validd); else passed++;
    imem_rdata = 32'h77;
    step();
    imem_ready = 1'b0;
    total++; if (instrd !== 32'h77) $display("FAIL rm_first_instr: got %h exp 00000077", instrd); else passed++;
    total++; if (pcplus4d !== 32'h4) $display("FAIL rm_first_pcp4: got %h exp 00000004", pcplus4d); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_var_latency();
    test_stall();
    test_branch_kill();
    test_jump_priority();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
